fifo_axis_packetizer: RTL and testbench
=======================================

# fifo_axis_packetizer

Egress stage that drains a first-word-fall-through single-clock byte FIFO and emits an AXI-Stream master with packet framing. A packet closes, with `m_axis_tlast`, when it reaches `MAX_LEN` beats or when the FIFO stays empty for `TIMEOUT` cycles. The block sits directly downstream of the switch-port FIFO and feeds the AXIS switch ingress.

## Interface
- `DWIDTH`, 8: data width of the FIFO word and of `m_axis_tdata`.
- `LEN_WIDTH`, 8: width of the beat counter. Legal range is 1 ≤ `MAX_LEN` < 2**`LEN_WIDTH`.
- `MAX_LEN`, 64: maximum beats per packet.
- `TIMEOUT`, 16: idle cycles before a held beat is closed as last; must be ≥ 1. Used only with `PKT_TIMEOUT_EN`.

Ports, clock and reset first:
- `clk`  in  1  single clock; all state on its rising edge.
- `res`  in  1  reset, asynchronous and active-high.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_read`  out  1  combinational pop strobe, sampled by the FIFO at the next edge.
- `fifo_read_value`  in  DWIDTH  FIFO head word, valid while `!fifo_empty`.
- `m_axis_tvalid`  out  1  beat valid.
- `m_axis_tready`  in  1  downstream ready.
- `m_axis_tdata`  out  DWIDTH  beat data.
- `m_axis_tlast`  out  1  last beat of packet.
- `pkt_done`  out  1  one-cycle pulse on the handshake of a `tlast` beat.

## Operation
- One word is always held back, so `tlast` can be decided when the next word arrives or the timer expires.
- Registers: `hold` (DWIDTH), `beat_cnt` (LEN_WIDTH), `idle_cnt` ($clog2(TIMEOUT+1)), `last_q`, `state`.

State machine:
- ST_EMPTY
  - If `!fifo_empty`: `fifo_read`=1, `hold`<=head, `beat_cnt`+1.
  - If the new count equals `MAX_LEN`, go to ST_OUT with `last_q`=1. Otherwise go to ST_HELD with `idle_cnt`=0.
- ST_HELD (nothing presented)
  - If `!fifo_empty`, go to ST_OUT with `last_q`=0. No pop.
  - Otherwise, if `idle_cnt`==TIMEOUT-1, go to ST_OUT with `last_q`=1. Otherwise `idle_cnt`+1.
- ST_OUT
  - `m_axis_tvalid`=1, `tdata`=`hold`, `tlast`=`last_q`.
  - On handshake with `last_q`=1: `beat_cnt`<=0, `pkt_done` pulse, go to ST_EMPTY.
  - On handshake with `last_q`=0: `fifo_read`=1 (the FIFO is guaranteed non-empty), capture the head and count it. Then apply the same `MAX_LEN` rule as ST_EMPTY.

Rules:
- `fifo_read` = (ST_EMPTY & !fifo_empty) | (ST_OUT & tvalid & tready & !last_q). It is never asserted otherwise.
- AXIS: `tdata`/`tlast` stay stable while `tvalid & !tready`. `tvalid` never drops without a handshake.
- Simultaneous events in ST_HELD: data arriving in the expiry cycle wins, so the held beat goes out with `tlast`=0.
- `MAX_LEN`=1: every beat carries `tlast`, and ST_HELD is never entered.
- `beat_cnt` never wraps. It is cleared on the `tlast` handshake and stays ≤ `MAX_LEN`.
- Reset mid-packet: the held word is discarded. FIFO contents are untouched (the FIFO has its own reset).

## Timing
- Reset values: `state`=ST_EMPTY; `m_axis_tvalid`, `m_axis_tlast`, `pkt_done` = 0; `m_axis_tdata`=0; `fifo_read`=0; all counters 0.
- Latency from FIFO non-empty to `tvalid`:
  - 2 cycles when a following word is already present (ST_EMPTY → ST_HELD → ST_OUT).
  - 1 cycle when `MAX_LEN` is reached.
- Timeout close: `TIMEOUT` cycles in ST_HELD, then `tvalid` on the next cycle.
- Throughput: one beat per 2 cycles in steady state (ST_OUT/ST_HELD alternation).

## Configuration
- Macro `PKT_TIMEOUT_EN`.
- Defined: `idle_cnt` is present and the timeout close behaves as above.
- Undefined:
  - ST_HELD leaves only on `!fifo_empty`.
  - Packets close only at `MAX_LEN`.
  - A trailing word is held indefinitely.
  - `idle_cnt` is not synthesised.

## Structure
- Package `pkt_pkg`: `typedef enum logic [1:0] {ST_EMPTY, ST_HELD, ST_OUT} pkt_state_t;` plus the default `MAX_LEN`/`TIMEOUT` constants.
- One natural sub-module: `pkt_idle_timer` (clear, enable, expire flag). It is instantiated only under `PKT_TIMEOUT_EN`.

## Test plan
All scenarios use MAX_LEN=4, TIMEOUT=8.
- Push 0x10..0x13, tready=1 → four beats; `tlast` on 0x13 only; one `pkt_done`; `beat_cnt` back to 0.
- Push 0xA0, 0xA1, then idle → 0xA0 goes out with `tlast`=0; 0xA1 is held 8 cycles, then goes out with `tlast`=1.
- Hold tready=0 for 5 cycles on beat 0x55 → `tdata`/`tlast` stable, `fifo_read`=0 throughout, no pop until the handshake.
- Push 0xB1 in the cycle `idle_cnt`==7 while 0xB0 is held → 0xB0 goes out with `tlast`=0; 0xB1 continues the same packet.
- Assert `res` while in ST_OUT → `tvalid`=0 immediately (asynchronously); after release the state is ST_EMPTY and `fifo_read`=0.
- Without `PKT_TIMEOUT_EN`: push 0x77 and idle 100 cycles → no `tvalid`. Push 0x78 → 0x77 is emitted with `tlast`=0.

Source files
------------

// File: rtl/fifo_axis_packetizer_pkg.sv
// Shared types and default constants for the FIFO-to-AXIS packetizer.
package pkt_pkg;

  typedef enum logic [1:0] {ST_EMPTY, ST_HELD, ST_OUT} pkt_state_t;

  localparam int unsigned PKT_MAX_LEN_DEF = 64;
  localparam int unsigned PKT_TIMEOUT_DEF = 16;

  function automatic int unsigned idle_width(input int unsigned timeout);
    return (timeout < 2) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/fifo_axis_packetizer_if.sv
// FIFO read side plus AXI-Stream master side of the packetizer.
interface fifo_axis_packetizer_if #(parameter int unsigned DWIDTH = 8);
  logic              fifo_empty;
  logic              fifo_read;
  logic [DWIDTH-1:0] fifo_read_value;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic [DWIDTH-1:0] m_axis_tdata;
  logic              m_axis_tlast;

  modport master (
    input  fifo_empty, fifo_read_value, m_axis_tready,
    output fifo_read, m_axis_tvalid, m_axis_tdata, m_axis_tlast
  );

  modport slave (
    output fifo_empty, fifo_read_value, m_axis_tready,
    input  fifo_read, m_axis_tvalid, m_axis_tdata, m_axis_tlast
  );
endinterface

// File: rtl/fifo_axis_packetizer_idle_timer.sv
// Idle-cycle counter: cleared outside the held state, saturates at TIMEOUT-1.
module pkt_idle_timer
  import pkt_pkg::*;
#(
  parameter int unsigned TIMEOUT = PKT_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic res,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);
  localparam int unsigned IW = idle_width(TIMEOUT);
  localparam logic [IW-1:0] LAST_IDLE = IW'(TIMEOUT - 1);

  logic [IW-1:0] idle_cnt_q, idle_cnt_d;

  assign expire_o = (idle_cnt_q == LAST_IDLE);

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (clear_i) begin
      idle_cnt_d = '0;
    end else if (enable_i && !expire_o) begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) idle_cnt_q <= '0;
    else     idle_cnt_q <= idle_cnt_d;
  end
endmodule

// File: rtl/fifo_axis_packetizer.sv
// Drains a FWFT FIFO into AXI-Stream packets closed at MAX_LEN beats or, when
// PKT_TIMEOUT_EN is defined, after TIMEOUT idle cycles with a word held back.
module fifo_axis_packetizer
  import pkt_pkg::*;
#(
  parameter int unsigned DWIDTH    = 8,
  parameter int unsigned LEN_WIDTH = 8,
  parameter int unsigned MAX_LEN   = PKT_MAX_LEN_DEF,
  parameter int unsigned TIMEOUT   = PKT_TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   res,
  fifo_axis_packetizer_if.master bus,
  output logic                   pkt_done
);
  localparam logic [LEN_WIDTH-1:0] MAX_CNT = LEN_WIDTH'(MAX_LEN);

  pkt_state_t           state_q, state_d;
  logic [DWIDTH-1:0]    hold_q, hold_d;
  logic [LEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d, cnt_inc;
  logic                 last_q, last_d;
  logic                 handshake, pop, expire;

  assign handshake         = (state_q == ST_OUT) && bus.m_axis_tready;
  assign cnt_inc           = beat_cnt_q + 1'b1;
  assign bus.m_axis_tvalid = (state_q == ST_OUT);
  assign bus.m_axis_tdata  = hold_q;
  assign bus.m_axis_tlast  = (state_q == ST_OUT) && last_q;
  // Keep the pop strobe quiet while reset holds the FSM in ST_EMPTY.
  assign bus.fifo_read     = pop && !res;
  assign pkt_done          = handshake && last_q;

`ifdef PKT_TIMEOUT_EN
  pkt_idle_timer #(.TIMEOUT(TIMEOUT)) u_idle (
    .clk      (clk),
    .res      (res),
    .clear_i  (state_q != ST_HELD),
    .enable_i ((state_q == ST_HELD) && bus.fifo_empty),
    .expire_o (expire)
  );
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    beat_cnt_d = beat_cnt_q;
    last_d     = last_q;
    pop        = 1'b0;
    case (state_q)
      ST_EMPTY: if (!bus.fifo_empty) pop = 1'b1;
      ST_HELD: begin
        // A word arriving in the expiry cycle takes priority over the timeout.
        if (!bus.fifo_empty) begin
          state_d = ST_OUT;
          last_d  = 1'b0;
        end else if (expire) begin
          state_d = ST_OUT;
          last_d  = 1'b1;
        end
      end
      ST_OUT: begin
        if (handshake) begin
          if (last_q) begin
            beat_cnt_d = '0;
            last_d     = 1'b0;
            state_d    = ST_EMPTY;
          end else begin
            pop = 1'b1;
          end
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (pop) begin
      hold_d     = bus.fifo_read_value;
      beat_cnt_d = cnt_inc;
      if (cnt_inc == MAX_CNT) begin
        state_d = ST_OUT;
        last_d  = 1'b1;
      end else begin
        state_d = ST_HELD;
      end
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q    <= ST_EMPTY;
      hold_q     <= '0;
      beat_cnt_q <= '0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      beat_cnt_q <= beat_cnt_d;
      last_q     <= last_d;
    end
  end
endmodule

// File: tb/tb_fifo_axis_packetizer.sv
// Bench for fifo_axis_packetizer with MAX_LEN=4, TIMEOUT=8; adapts to PKT_TIMEOUT_EN.
module tb_fifo_axis_packetizer;
  import pkt_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned LW = 8;
  localparam int unsigned ML = 4;
  localparam int unsigned TO = 8;
`ifdef PKT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic clk = 1'b0;
  logic res = 1'b1;
  logic pkt_done;

  fifo_axis_packetizer_if #(.DWIDTH(DW)) pif ();

  fifo_axis_packetizer #(
    .DWIDTH(DW), .LEN_WIDTH(LW), .MAX_LEN(ML), .TIMEOUT(TO)
  ) dut (
    .clk      (clk),
    .res      (res),
    .bus      (pif.master),
    .pkt_done (pkt_done)
  );

  always #5 clk = ~clk;

  logic [7:0] fifo_q[$];
  beat_t      exp_q[$];
  int         pos, checks, passes, cyc, hs_cyc, rise_cyc, rdy_mode;
  logic       prev_stall, prev_valid, prev_last;
  logic [7:0] prev_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive_fifo();
    pif.fifo_empty      = (fifo_q.size() == 0);
    pif.fifo_read_value = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  // Packet rule: close at the MAX_LEN-th word, or at the end of a burst when timeouts exist.
  task automatic expect_word(input logic [7:0] d, input bit eob);
    beat_t b;
    pos++;
    b.data = d;
    b.last = (pos == ML) || (TO_EN && eob);
    if (b.last) pos = 0;
    exp_q.push_back(b);
  endtask

  task automatic push_word(input logic [7:0] d, input bit eob);
    fifo_q.push_back(d);
    expect_word(d, eob);
    drive_fifo();
  endtask

  task automatic model_reset();
    exp_q.delete();
    pos = 0;
    prev_stall = 1'b0;
    foreach (fifo_q[i]) expect_word(fifo_q[i], i == fifo_q.size() - 1);
  endtask

  task automatic tick();
    logic hs, pd_exp, popped;
    @(negedge clk);
    cyc++;
    hs = pif.m_axis_tvalid && pif.m_axis_tready;
    if (!res && prev_stall) begin
      chk("stall_valid", pif.m_axis_tvalid, 1);
      chk("stall_data", pif.m_axis_tdata, prev_data);
      chk("stall_last", pif.m_axis_tlast, prev_last);
    end
    if (pif.m_axis_tvalid && !prev_valid) rise_cyc = cyc;
    chk("read_when_empty", pif.fifo_read && pif.fifo_empty, 0);
    if (pif.m_axis_tvalid && !pif.m_axis_tready) chk("read_in_stall", pif.fifo_read, 0);
    pd_exp = hs && (exp_q.size() > 0) && exp_q[0].last;
    chk("pkt_done", pkt_done, pd_exp);
    if (hs) begin
      hs_cyc = cyc;
      chk("beat_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        chk("tdata", pif.m_axis_tdata, exp_q[0].data);
        chk("tlast", pif.m_axis_tlast, exp_q[0].last);
        void'(exp_q.pop_front());
      end
    end
    prev_stall = !res && pif.m_axis_tvalid && !pif.m_axis_tready;
    prev_valid = pif.m_axis_tvalid;
    prev_data  = pif.m_axis_tdata;
    prev_last  = pif.m_axis_tlast;
    popped     = pif.fifo_read;
    @(posedge clk);
    #1;
    if (popped && fifo_q.size() > 0) void'(fifo_q.pop_front());
    drive_fifo();
    case (rdy_mode)
      0:       pif.m_axis_tready = 1'b1;
      1:       pif.m_axis_tready = 1'($urandom_range(0, 1));
      default: pif.m_axis_tready = 1'b0;
    endcase
  endtask

  task automatic drain();
    int n = 0;
    while (!(exp_q.size() == 0 ||
             (exp_q.size() == 1 && !exp_q[0].last && fifo_q.size() == 0)) && n < 3000) begin
      tick();
      n++;
    end
    chk("drain_in_budget", n < 3000, 1);
    repeat (3) tick();
  endtask

  initial begin
    int n, len;
    checks = 0; passes = 0; pos = 0; cyc = 0; hs_cyc = 0; rise_cyc = 0;
    prev_stall = 1'b0; prev_valid = 1'b0; prev_last = 1'b0; prev_data = '0;
    rdy_mode = 0;
    pif.m_axis_tready = 1'b1;
    drive_fifo();

    repeat (2) @(posedge clk);
    #1;
    chk("rst_tvalid", pif.m_axis_tvalid, 0);
    chk("rst_tlast", pif.m_axis_tlast, 0);
    chk("rst_tdata", pif.m_axis_tdata, 0);
    chk("rst_pkt_done", pkt_done, 0);
    chk("rst_fifo_read", pif.fifo_read, 0);
    chk("rst_beat_cnt", dut.beat_cnt_q, 0);
    res = 1'b0;

    for (int i = 0; i < 4; i++) push_word(8'(8'h10 + i), i == 3);
    drain();
    chk("beat_cnt_cleared", dut.beat_cnt_q, 0);
    chk("state_after_pkt", dut.state_q, ST_EMPTY);

`ifdef PKT_TIMEOUT_EN
    push_word(8'hA0, 1'b0);
    push_word(8'hA1, 1'b1);
    n = 0;
    while (exp_q.size() > 1 && n < 100) begin tick(); n++; end
    n = 0;
    while (rise_cyc <= hs_cyc && n < 100) begin tick(); n++; end
    chk("timeout_latency", rise_cyc - hs_cyc, TO + 1);
    drain();

    push_word(8'hB0, 1'b0);
    repeat (TO) tick();
    chk("idle_at_b1", dut.u_idle.idle_cnt_q, TO - 1);
    push_word(8'hB1, 1'b1);
    drain();
`endif

    rdy_mode = 2;
    pif.m_axis_tready = 1'b0;
    push_word(8'h55, 1'b0);
    push_word(8'h56, 1'b1);
    n = 0;
    while (!pif.m_axis_tvalid && n < 50) begin tick(); n++; end
    repeat (5) tick();
    chk("stall_holds_0x55", pif.m_axis_tdata, 8'h55);
    chk("stall_no_pop", fifo_q.size(), 1);
    rdy_mode = 0;
    pif.m_axis_tready = 1'b1;
    drain();

    rdy_mode = 2;
    pif.m_axis_tready = 1'b0;
    push_word(8'h60, 1'b0);
    push_word(8'h61, 1'b1);
    n = 0;
    while (!pif.m_axis_tvalid && n < 50) begin tick(); n++; end
    chk("reached_out", pif.m_axis_tvalid, 1);
    #2 res = 1'b1;
    #1;
    chk("async_rst_tvalid", pif.m_axis_tvalid, 0);
    chk("async_rst_tlast", pif.m_axis_tlast, 0);
    chk("async_rst_tdata", pif.m_axis_tdata, 0);
    chk("async_rst_read", pif.fifo_read, 0);
    model_reset();
    tick();
    tick();
    res = 1'b0;
    #1;
    chk("post_rst_state", dut.state_q, ST_EMPTY);
    chk("post_rst_tvalid", pif.m_axis_tvalid, 0);
    rdy_mode = 1;
    drain();

`ifndef PKT_TIMEOUT_EN
    res = 1'b1;
    tick();
    res = 1'b0;
    model_reset();
    rdy_mode = 0;
    push_word(8'h77, 1'b1);
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("idle_no_tvalid", pif.m_axis_tvalid, 0);
    end
    push_word(8'h78, 1'b1);
    drain();
    chk("trailing_held", exp_q.size(), 1);
`endif

    for (int r = 0; r < 25; r++) begin
      rdy_mode = int'($urandom_range(0, 1));
      len = int'($urandom_range(1, 9));
      for (int i = 0; i < len; i++) push_word(8'($urandom), i == len - 1);
      drain();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
